// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, START/RUN/HALT sequencing and the IF/ID pipeline register.
// Optional performance counters are enabled with `define IF_FETCH_PERF_CNT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] instruction,
  output logic [31:0] read_adress,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] reset_pc_aligned;
  logic [31:0] redirect_pc;
  logic        capture_valid;
  logic        bubble;

  assign pc_plus4         = pc_q + 32'd4;
  assign reset_pc_aligned = {RESET_PC[31:2], 2'b00};
  assign redirect_pc      = branch_target & 32'hFFFF_FFFC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    capture_valid = 1'b0;
    bubble        = 1'b0;
    if (flush) begin
      // Redirect wins over stall in every state; if_id_pc4 is left untouched.
      pc_d    = redirect_pc;
      instr_d = '0;
      valid_d = 1'b0;
      state_d = RUN;
      bubble  = (state_q == RUN);
    end else begin
      unique case (state_q)
        START: state_d = RUN;
        RUN: begin
          if (stall) begin
            bubble = 1'b1;
          end else begin
            capture_valid = 1'b1;
            instr_d       = instruction;
            pc4_d         = pc_plus4;
            valid_d       = 1'b1;
            if (instruction == HALT_WORD) begin
              state_d = HALT;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        HALT: begin
          if (!stall) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= START;
      pc_q    <= reset_pc_aligned;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign read_adress = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == HALT);

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (capture_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = capture_valid | bubble;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table through a scoreboard queue plus a wrap-around sequence.
module tb_if_fetch;

  logic        clk;
  logic        rst_n, stall, flush;
  logic [31:0] branch_target;
  logic [31:0] instruction, read_adress, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted;

  logic        rst_w;
  logic [31:0] instr_w, addr_w, w_instr, w_pc4;
  logic        w_valid, w_halted;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count, w_fcnt, w_bcnt;
`endif

  logic [31:0] mem [256];

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] bt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] fcnt;
    logic [31:0] bcnt;
  } vec_t;

  vec_t vecs [23];
  vec_t sb [$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_target(branch_target), .instruction(instruction),
    .read_adress(read_adress), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
`ifdef IF_FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .halted(halted)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_w), .stall(1'b0), .flush(1'b0),
    .branch_target(32'h0), .instruction(instr_w),
    .read_adress(addr_w), .if_id_instr(w_instr),
    .if_id_pc4(w_pc4), .if_id_valid(w_valid),
`ifdef IF_FETCH_PERF_CNT_EN
    .fetch_count(w_fcnt), .bubble_count(w_bcnt),
`endif
    .halted(w_halted)
  );

  assign instruction = mem[8'(read_adress >> 2)];
  assign instr_w     = mem[8'(addr_w >> 2)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] bt,
                              input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4,
                              input logic v, input logic h, input logic [31:0] fc, input logic [31:0] bc);
    vec_t t;
    t.rst_n = r; t.stall = s; t.flush = f; t.bt = bt;
    t.pc = pc; t.instr = ins; t.pc4 = p4; t.valid = v; t.halted = h;
    t.fcnt = fc; t.bcnt = bc;
    return t;
  endfunction

  task automatic compare_all(input string tag, input vec_t e);
    check({tag, ".pc"},     read_adress, e.pc);
    check({tag, ".instr"},  if_id_instr, e.instr);
    check({tag, ".pc4"},    if_id_pc4,   e.pc4);
    check({tag, ".valid"},  {31'b0, if_id_valid}, {31'b0, e.valid});
    check({tag, ".halted"}, {31'b0, halted},      {31'b0, e.halted});
`ifdef IF_FETCH_PERF_CNT_EN
    check({tag, ".fcnt"}, fetch_count,  e.fcnt);
    check({tag, ".bcnt"}, bubble_count, e.bcnt);
`endif
  endtask

  initial begin
    vec_t e;
    n_tests = 0;
    n_fail  = 0;

    for (int unsigned i = 0; i < 256; i++) mem[i] = 32'h100 + i;
    mem[0]   = 32'h11;
    mem[1]   = 32'h22;
    mem[2]   = 32'h33;
    mem[3]   = 32'h44;
    mem[4]   = 32'hFFFF_FFFF;
    mem[16]  = 32'hA0;
    mem[255] = 32'hCC;

    //            rst st fl bt          pc           instr        pc4          v  h  fcnt bcnt
    vecs[0]  = mk(1, 0, 0, 32'h0,  32'h0,  32'h0,        32'h0,  0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,  32'h4,  32'h11,       32'h4,  1, 0, 1, 0);
    vecs[2]  = mk(1, 0, 0, 32'h0,  32'h8,  32'h22,       32'h8,  1, 0, 2, 0);
    vecs[3]  = mk(1, 1, 0, 32'h0,  32'h8,  32'h22,       32'h8,  1, 0, 2, 1);
    vecs[4]  = mk(1, 1, 0, 32'h0,  32'h8,  32'h22,       32'h8,  1, 0, 2, 2);
    vecs[5]  = mk(1, 1, 0, 32'h0,  32'h8,  32'h22,       32'h8,  1, 0, 2, 3);
    vecs[6]  = mk(1, 0, 0, 32'h0,  32'hC,  32'h33,       32'hC,  1, 0, 3, 3);
    vecs[7]  = mk(1, 0, 0, 32'h0,  32'h10, 32'h44,       32'h10, 1, 0, 4, 3);
    vecs[8]  = mk(1, 0, 0, 32'h0,  32'h10, 32'hFFFF_FFFF, 32'h14, 1, 1, 5, 3);
    for (int unsigned i = 9; i <= 13; i++)
      vecs[i] = mk(1, 0, 0, 32'h0, 32'h10, 32'hFFFF_FFFF, 32'h14, 0, 1, 5, 3);
    vecs[14] = mk(1, 0, 1, 32'h0,  32'h0,  32'h0,        32'h14, 0, 0, 5, 3);
    vecs[15] = mk(1, 0, 0, 32'h0,  32'h4,  32'h11,       32'h4,  1, 0, 6, 3);
    vecs[16] = mk(1, 1, 1, 32'h43, 32'h40, 32'h0,        32'h4,  0, 0, 6, 4);
    vecs[17] = mk(1, 0, 0, 32'h0,  32'h44, 32'hA0,       32'h44, 1, 0, 7, 4);
    vecs[18] = mk(1, 0, 1, 32'h20, 32'h20, 32'h0,        32'h44, 0, 0, 7, 5);
    vecs[19] = mk(1, 1, 0, 32'h0,  32'h20, 32'h0,        32'h44, 0, 0, 7, 6);
    vecs[20] = mk(0, 1, 0, 32'h0,  32'h0,  32'h0,        32'h0,  0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 32'h0,  32'h0,  32'h0,        32'h0,  0, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 32'h0,  32'h4,  32'h11,       32'h4,  1, 0, 1, 0);

    rst_n = 1'b0; rst_w = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset", mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0));

    for (int unsigned i = 0; i < 23; i++) begin
      rst_n         = vecs[i].rst_n;
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      branch_target = vecs[i].bt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare_all($sformatf("row%0d", i), e);
    end
    stall = 1'b0;
    flush = 1'b0;

    // Wrap-around instance held in reset through the table; PC starts at the top word.
    check("wrap.reset_pc", addr_w, 32'hFFFF_FFFC);
    check("wrap.reset_valid", {31'b0, w_valid}, 32'h0);
    rst_w = 1'b1;
    @(posedge clk); #1;
    check("wrap.start_pc", addr_w, 32'hFFFF_FFFC);
    check("wrap.start_valid", {31'b0, w_valid}, 32'h0);
    @(posedge clk); #1;
    check("wrap.instr", w_instr, 32'hCC);
    check("wrap.pc4", w_pc4, 32'h0);
    check("wrap.next_pc", addr_w, 32'h0);
    @(posedge clk); #1;
    check("wrap.instr2", w_instr, 32'h11);
    check("wrap.pc4_2", w_pc4, 32'h4);
    check("wrap.halted", {31'b0, w_halted}, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    check("wrap.fcnt", w_fcnt, 32'h2);
    check("wrap.bcnt", w_bcnt, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded by reset; bits [1:0] SHALL be treated as zero.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold PC and IF/ID register.
- flush  in  1  redirect request (taken branch/jump).
- branch_target  in  32  redirect address.
- instruction  in  32  word returned by instruction memory.
- read_adress  out  32  byte address to instruction memory, equal to pc.
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  32  registered pc+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on halt word.

Function
REQ-003 Memory read SHALL be combinational: instruction corresponds to read_adress in the same cycle; the memory indexes words with read_adress[31:2].
REQ-004 FSM SHALL have states START, RUN and HALT.
REQ-005 START SHALL be entered on reset and SHALL last one cycle, with no IF/ID capture and a transition to RUN.
REQ-006 In RUN, with stall=0 and flush=0:
- pc SHALL advance to pc+4 each cycle, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID SHALL capture instruction, pc+4 and valid=1.
REQ-007 In RUN, with stall=1 and flush=0, pc, if_id_instr, if_id_pc4 and if_id_valid SHALL all hold their values.
REQ-008 When flush=1, in any state and regardless of stall:
- pc SHALL load {branch_target[31:2],2'b00}.
- if_id_valid SHALL clear to 0 and if_id_instr SHALL load 32'h0000_0000.
- The FSM SHALL go to RUN.
- flush SHALL win over stall.
REQ-009 When, in RUN, stall=0, flush=0 and instruction==32'hFFFF_FFFF, the halt word SHALL be captured into IF/ID as a valid instruction, pc SHALL hold, and the FSM SHALL enter HALT.
REQ-010 In HALT:
- pc SHALL hold.
- The next non-stalled cycle SHALL load if_id_valid=0.
- halted SHALL be 1.
- Only flush or reset SHALL exit HALT.
REQ-011 halted SHALL be 1 only in HALT; read_adress SHALL always equal pc.
REQ-012 if_id_pc4 SHALL be computed with a 32-bit adder with the carry dropped.

Reset
REQ-013 With rst_n=0 at a rising clk edge, the following SHALL take effect on that edge, overriding stall and flush:
- pc=RESET_PC with bits [1:0]=0.
- FSM=START.
- if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0.
REQ-014 Reset asserted mid-operation, including in HALT, SHALL discard all in-flight state; with rst_n=0 there SHALL be no asynchronous effect between edges.

Configuration
REQ-015 Macro IF_FETCH_PERF_CNT_EN, when defined, SHALL add these outputs:
- fetch_count  out  32  counts cycles in which IF/ID captures with valid=1.
- bubble_count  out  32  counts cycles in which a flush or stall occurs in RUN.
- Both counters SHALL be cleared by reset and SHALL wrap at 2^32.
REQ-016 When IF_FETCH_PERF_CNT_EN is undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-017 Reset then run: hold rst_n=0 for 2 cycles, then release with memory words 0..3 = 0x11,0x22,0x33,0x44 -> first cycle after release shows if_id_valid=0 and pc=0; the following edges show if_id_instr=0x11,0x22,0x33 with if_id_pc4=4,8,12.
REQ-018 Stall: assert stall for 3 cycles at pc=8 -> pc stays 8 and IF/ID stays frozen; after release the next capture is the word at address 8.
REQ-019 Flush beats stall: assert stall=1 and flush=1 together with branch_target=0x0000_0043 -> pc=0x40, if_id_valid=0 and if_id_instr=0 on the next edge.
REQ-020 Halt: memory word at 0x10 = 0xFFFF_FFFF -> halt word captured valid; halted=1 and pc=0x10 held for 5 cycles; a following flush to 0 restarts fetch with halted=0.
REQ-021 Wrap-around: RESET_PC=0xFFFF_FFFC -> capture shows if_id_pc4=0 and the next pc=0.
REQ-022 Reset mid-run: assert rst_n=0 for 1 cycle at pc=0x20 while halted or stalled -> all outputs return to their reset values on that edge; with IF_FETCH_PERF_CNT_EN defined, fetch_count=0 and bubble_count=0.
